// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-atomic sharing of one uart_tx among N_REQ byte streams (optional `UART_ARB_TIMEOUT_EN).
// Latency: grant one edge after req is sampled in IDLE, uart_tx_en/req_ack one edge later; outputs registered.
// Backpressure: a byte is taken only while uart_tx_busy is low; a stalled owner holds the grant (or is released after TIMEOUT_CYC).
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*8-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ack,
  output logic [N_REQ-1:0]   grant,
  output logic               uart_tx_en,
  output logic [7:0]         uart_tx_data,
  input  logic               uart_tx_busy,
  output logic               arb_timeout
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_START,
    S_WAIT_DONE
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [IW-1:0]    r_gidx, w_gidx_nxt;
  logic [IW-1:0]    r_rr_ptr, w_rr_ptr_nxt;
  logic [N_REQ-1:0] r_grant, w_grant_nxt;
  logic [N_REQ-1:0] r_req_ack, w_req_ack_nxt;
  logic             r_tx_en, w_tx_en_nxt;
  logic [7:0]       r_tx_data, w_tx_data_nxt;
  logic             r_last_q, w_last_q_nxt;
  logic             r_arb_timeout, w_arb_timeout_nxt;

  logic             w_g_req;
  logic             w_g_last;
  logic [7:0]       w_g_data;
  logic             w_found;
  logic [IW-1:0]    w_pick;
  logic [N_REQ-1:0] w_pick_oh;
  logic             w_to_hit;

  // Select the current owner's byte-valid, last flag and data (grant is one-hot or zero)
  always_comb begin
    w_g_req  = 1'b0;
    w_g_last = 1'b0;
    w_g_data = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant[i]) begin
        w_g_req  = req[i];
        w_g_last = req_last[i];
        w_g_data = req_data[8*i +: 8];
      end
    end
  end

  // Round-robin search starting just after the last served requester
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_rr_ptr;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!w_found && req[IW'((int'(r_rr_ptr) + k) % N_REQ)]) begin
        w_found = 1'b1;
        w_pick  = IW'((int'(r_rr_ptr) + k) % N_REQ);
      end
    end
  end

  assign w_pick_oh = N_REQ'(1) << w_pick;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYC + 1) > 16) ? $clog2(TIMEOUT_CYC + 1) : 16;
  logic [TW-1:0] r_to_cnt;

  // Count consecutive cycles the owner sits in LOAD without presenting a byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (r_state == S_LOAD && !w_g_req) begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end else begin
      r_to_cnt <= '0;
    end
  end

  assign w_to_hit = (r_state == S_LOAD) && !w_g_req && (r_to_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign w_to_hit = 1'b0;
`endif

  // Next-state and next-output logic; pulses default low, held values default to current
  always_comb begin
    w_state_nxt       = r_state;
    w_gidx_nxt        = r_gidx;
    w_rr_ptr_nxt      = r_rr_ptr;
    w_grant_nxt       = r_grant;
    w_req_ack_nxt     = '0;
    w_tx_en_nxt       = 1'b0;
    w_tx_data_nxt     = r_tx_data;
    w_last_q_nxt      = r_last_q;
    w_arb_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_pick_oh;
          w_gidx_nxt  = w_pick;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_g_req && !uart_tx_busy) begin
          w_tx_en_nxt   = 1'b1;
          w_tx_data_nxt = w_g_data;
          w_req_ack_nxt = r_grant;
          w_last_q_nxt  = w_g_last;
          w_state_nxt   = S_WAIT_START;
        end else if (w_to_hit) begin
          w_grant_nxt       = '0;
          w_rr_ptr_nxt      = r_gidx;
          w_arb_timeout_nxt = 1'b1;
          w_state_nxt       = S_IDLE;
        end
      end
      S_WAIT_START: begin
        if (uart_tx_busy) begin
          w_state_nxt = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (!uart_tx_busy) begin
          if (r_last_q) begin
            w_grant_nxt  = '0;
            w_rr_ptr_nxt = r_gidx;
            w_state_nxt  = S_IDLE;
          end else begin
            w_state_nxt = S_LOAD;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered outputs and packet bookkeeping; pointer resets so req[0] wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gidx        <= '0;
      r_rr_ptr      <= IW'(N_REQ - 1);
      r_grant       <= '0;
      r_req_ack     <= '0;
      r_tx_en       <= 1'b0;
      r_tx_data     <= 8'h00;
      r_last_q      <= 1'b0;
      r_arb_timeout <= 1'b0;
    end else begin
      r_gidx        <= w_gidx_nxt;
      r_rr_ptr      <= w_rr_ptr_nxt;
      r_grant       <= w_grant_nxt;
      r_req_ack     <= w_req_ack_nxt;
      r_tx_en       <= w_tx_en_nxt;
      r_tx_data     <= w_tx_data_nxt;
      r_last_q      <= w_last_q_nxt;
      r_arb_timeout <= w_arb_timeout_nxt;
    end
  end

  assign grant        = r_grant;
  assign req_ack      = r_req_ack;
  assign uart_tx_en   = r_tx_en;
  assign uart_tx_data = r_tx_data;
  assign arb_timeout  = r_arb_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester/uart_tx models, packet-level round-robin reference, directed + random traffic.
// Latency: expects grant one edge after req, uart_tx_en/req_ack the edge after that.
// Backpressure: uart_tx model holds busy 20 cycles, rising one cycle after each uart_tx_en.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 100;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ack;
  logic [N-1:0]   grant;
  logic           uart_tx_en;
  logic [7:0]     uart_tx_data;
  logic           uart_tx_busy;
  logic           arb_timeout;

  typedef struct { logic [7:0] d; logic last; } rbyte_t;
  typedef struct { logic [7:0] d; logic [N-1:0] g; } tx_t;

  rbyte_t rq[N][$];
  tx_t    exp_q[$];
  int     stall[N];
  int     ack_cnt[N];
  int     en_cnt;
  int     busy_cnt;
  int     mdl_ptr;
  int     n_checks;
  int     n_fail;
  bit     stall_en;
  bit     prev_en;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ack      (req_ack),
    .grant        (grant),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_data (uart_tx_data),
    .uart_tx_busy (uart_tx_busy),
    .arb_timeout  (arb_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Advance n cycles; main-thread actions happen 2 time units after the rising edge
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic bit queues_empty();
    bit e = 1'b1;
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic add_packet(input int r, input int len);
    for (int j = 0; j < len; j++) rq[r].push_back('{d: 8'($urandom), last: (j == len - 1)});
  endtask

  // Packet-level reference: serve whole packets in round-robin order over requesters with work left
  task automatic build_expected();
    rbyte_t tmp[N][$];
    rbyte_t b;
    int     p;
    bit     any;
    for (int i = 0; i < N; i++) tmp[i] = rq[i];
    p = mdl_ptr;
    do begin
      any = 1'b0;
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (p + k) % N;
        if (!any && tmp[i].size() > 0) begin
          any = 1'b1;
          p   = i;
          do begin
            b = tmp[i].pop_front();
            exp_q.push_back('{d: b.d, g: N'(1) << i});
          end while (!b.last && tmp[i].size() > 0);
        end
      end
    end while (any);
    mdl_ptr = p;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      rq[i].delete();
      stall[i] = 0;
    end
    exp_q.delete();
    cyc(2);
    rst_n   = 1'b1;
    mdl_ptr = N - 1;
    cyc(1);
  endtask

  task automatic wait_grant(input string tag, input logic [N-1:0] g, input int budget);
    int n = 0;
    while (grant !== g && n < budget) begin
      cyc(1);
      n++;
    end
    check_val(tag, 32'(grant), 32'(g));
  endtask

  task automatic wait_busy(input string tag, input logic lvl, input int budget);
    int n = 0;
    while (uart_tx_busy !== lvl && n < budget) begin
      cyc(1);
      n++;
    end
    check_val(tag, 32'(uart_tx_busy), 32'(lvl));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (!(queues_empty() && exp_q.size() == 0 && grant == '0 && !uart_tx_busy) && n < budget) begin
      cyc(1);
      n++;
    end
    check_val({tag, "_drained"}, 32'(n < budget), 32'(1));
  endtask

  // Monitor, uart_tx model and requester models, all acting on the falling edge
  initial begin
    tx_t    e;
    rbyte_t b;
    forever begin
      @(negedge clk);
      if (uart_tx_en) begin
        en_cnt++;
        check_val("en_pulse_1cyc", 32'(prev_en), 32'(0));
        check_val("ack_eq_grant", 32'(req_ack), 32'(grant));
        if (exp_q.size() == 0) begin
          check_val("unexpected_tx_en", 32'(uart_tx_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check_val("tx_data", 32'(uart_tx_data), 32'(e.d));
          check_val("tx_owner", 32'(grant), 32'(e.g));
        end
      end else if (req_ack != '0) begin
        check_val("ack_without_en", 32'(req_ack), 32'(0));
      end
`ifndef UART_ARB_TIMEOUT_EN
      if (arb_timeout) check_val("timeout_tied0", 32'(arb_timeout), 32'(0));
`endif
      prev_en = uart_tx_en;

      if (busy_cnt > 0) busy_cnt--;
      if (uart_tx_en) busy_cnt = 21;
      uart_tx_busy = (busy_cnt > 0 && busy_cnt <= 20);

      for (int i = 0; i < N; i++) begin
        if (req_ack[i]) begin
          ack_cnt[i]++;
          if (rq[i].size() > 0) begin
            b = rq[i].pop_front();
            if (!b.last && stall_en && $urandom_range(0, 2) == 0) stall[i] = $urandom_range(1, 40);
          end
        end
        if (stall[i] > 0) begin
          stall[i]--;
          req[i] = 1'b0;
        end else begin
          req[i] = (rq[i].size() > 0);
        end
        if (rq[i].size() > 0) begin
          req_data[8*i +: 8] = rq[i][0].d;
          req_last[i]        = rq[i][0].last;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int base;
    int n;
    rst_n        = 1'b0;
    req          = '0;
    req_data     = '0;
    req_last     = '0;
    uart_tx_busy = 1'b0;
    busy_cnt     = 0;
    en_cnt       = 0;
    n_checks     = 0;
    n_fail       = 0;
    stall_en     = 1'b0;
    prev_en      = 1'b0;
    mdl_ptr      = N - 1;
    for (int i = 0; i < N; i++) begin
      stall[i]   = 0;
      ack_cnt[i] = 0;
    end

    // Reset state
    cyc(3);
    check_val("rst_grant", 32'(grant), 32'(0));
    check_val("rst_ack", 32'(req_ack), 32'(0));
    check_val("rst_en", 32'(uart_tx_en), 32'(0));
    check_val("rst_data", 32'(uart_tx_data), 32'(0));
    check_val("rst_timeout", 32'(arb_timeout), 32'(0));
    rst_n = 1'b1;
    cyc(2);
    check_val("post_rst_grant", 32'(grant), 32'(0));

    // 3-byte packet from requester 1, with first-byte latency
    base = ack_cnt[1];
    rq[1].push_back('{d: 8'h41, last: 1'b0});
    rq[1].push_back('{d: 8'h42, last: 1'b0});
    rq[1].push_back('{d: 8'h43, last: 1'b1});
    build_expected();
    cyc(1);
    check_val("t1_grant_lat", 32'(grant), 32'(4'b0010));
    check_val("t1_no_en_yet", 32'(uart_tx_en), 32'(0));
    cyc(1);
    check_val("t1_en_lat", 32'(uart_tx_en), 32'(1));
    check_val("t1_ack_lat", 32'(req_ack), 32'(4'b0010));
    check_val("t1_data0", 32'(uart_tx_data), 32'h41);
    wait_idle("t1", 500);
    check_val("t1_ack_count", 32'(ack_cnt[1] - base), 32'(3));
    check_val("t1_grant_end", 32'(grant), 32'(0));

    // Simultaneous requests 0 and 2 after reset: 0 first
    do_reset();
    rq[0].push_back('{d: 8'hA0, last: 1'b1});
    rq[2].push_back('{d: 8'hA2, last: 1'b1});
    build_expected();
    wait_grant("t2_first", 4'b0001, 10);
    wait_grant("t2_second", 4'b0100, 100);
    wait_idle("t2", 500);

    // All requesters busy: rotation 0,1,2,3,0
    do_reset();
    rq[0].push_back('{d: 8'hB0, last: 1'b1});
    rq[0].push_back('{d: 8'hB4, last: 1'b1});
    rq[1].push_back('{d: 8'hB1, last: 1'b1});
    rq[2].push_back('{d: 8'hB2, last: 1'b1});
    rq[3].push_back('{d: 8'hB3, last: 1'b1});
    build_expected();
    wait_grant("t3_g0", 4'b0001, 10);
    wait_grant("t3_g1", 4'b0010, 100);
    wait_grant("t3_g2", 4'b0100, 100);
    wait_grant("t3_g3", 4'b1000, 100);
    wait_grant("t3_g0b", 4'b0001, 100);
    wait_idle("t3", 500);

    // Requester 0 arrives mid-packet of requester 3 and must wait for the packet end
    base = ack_cnt[3];
    add_packet(3, 4);
    build_expected();
    n = 0;
    while (ack_cnt[3] < base + 2 && n < 200) begin
      cyc(1);
      n++;
    end
    check_val("t4_two_bytes", 32'(ack_cnt[3] - base), 32'(2));
    rq[0].push_back('{d: 8'hC0, last: 1'b1});
    exp_q.push_back('{d: 8'hC0, g: 4'b0001});
    wait_grant("t4_grant0", 4'b0001, 300);
    check_val("t4_busy_low", 32'(uart_tx_busy), 32'(0));
    check_val("t4_r3_done", 32'(ack_cnt[3] - base), 32'(4));
    wait_idle("t4", 500);
    mdl_ptr = 0;

    // Reset while waiting for a byte to finish
    rq[1].push_back('{d: 8'h10, last: 1'b0});
    rq[1].push_back('{d: 8'h11, last: 1'b1});
    build_expected();
    base = en_cnt;
    n = 0;
    while (en_cnt == base && n < 20) begin
      cyc(1);
      n++;
    end
    check_val("t5_first_en", 32'(en_cnt - base), 32'(1));
    cyc(5);
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      rq[i].delete();
      stall[i] = 0;
    end
    exp_q.delete();
    #1;
    check_val("t5_rst_grant", 32'(grant), 32'(0));
    check_val("t5_rst_ack", 32'(req_ack), 32'(0));
    check_val("t5_rst_en", 32'(uart_tx_en), 32'(0));
    cyc(2);
    rst_n   = 1'b1;
    mdl_ptr = N - 1;
    base    = en_cnt;
    cyc(40);
    check_val("t5_no_en_after", 32'(en_cnt - base), 32'(0));
    check_val("t5_grant_idle", 32'(grant), 32'(0));

    // Randomized packet mixes with mid-packet requester stalls
    wait_idle("pre_rand", 100);
    stall_en = 1'b1;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) != 0) begin
          n = $urandom_range(1, 3);
          for (int p = 0; p < n; p++) add_packet(i, $urandom_range(1, 4));
        end
      end
      build_expected();
      wait_idle("rand", 5000);
    end
    stall_en = 1'b0;

    // Owner abandons its packet after a non-last byte
    do_reset();
    rq[2].push_back('{d: 8'h55, last: 1'b0});
    exp_q.push_back('{d: 8'h55, g: 4'b0100});
    wait_grant("t6_grant2", 4'b0100, 10);
    rq[1].push_back('{d: 8'h66, last: 1'b1});
    wait_busy("t6_busy_hi", 1'b1, 10);
    wait_busy("t6_busy_lo", 1'b0, 40);
`ifdef UART_ARB_TIMEOUT_EN
    exp_q.push_back('{d: 8'h66, g: 4'b0010});
    n = 0;
    while (!arb_timeout && n < 3 * TO) begin
      cyc(1);
      n++;
    end
    check_val("t6_timeout_cycles", 32'(n), 32'(TO));
    check_val("t6_timeout_grant", 32'(grant), 32'(0));
    cyc(1);
    check_val("t6_timeout_pulse", 32'(arb_timeout), 32'(0));
    wait_grant("t6_next_owner", 4'b0010, 5);
    wait_idle("t6", 500);
`else
    cyc(3 * TO / 2);
    check_val("t6_grant_held", 32'(grant), 32'(4'b0100));
    check_val("t6_no_timeout", 32'(arb_timeout), 32'(0));
    do_reset();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
